// File: rtl/cnt_bus_arbiter_pkg.sv
// Shared constants, request bundle type and small index helpers for the
// controller BRAM port arbiter.
package cnt_arb;

    localparam int NUM_REQ_MAX      = 8;
    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_ADDR_WIDTH   = 8;
    localparam int DEF_DATA_WIDTH   = 16;
    localparam int DEF_RD_LATENCY   = 2;
    localparam int DEF_LOCK_TIMEOUT = 64;

    typedef struct packed {
        logic                      we;
        logic                      lock;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] wdata;
    } cnt_req_t;

    // Owner-id width; a single requester still needs one bit to hold an id.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/cnt_bus_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or above the pointer,
// wrapping modulo N, returned as a one-hot grant.
module rr_pick
    import cnt_arb::*;
#(
    parameter  int N   = DEF_NUM_REQ,
    localparam int IDW = id_width(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt
);

    logic           found;
    logic [IDW-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = IDW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cnt_bus_arbiter.sv
// Round-robin arbiter for the single controller BRAM port, with locked bursts,
// lock timeout and per-requester read-data return.
module cnt_bus_arbiter
    import cnt_arb::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int RD_LATENCY   = DEF_RD_LATENCY,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            we,
    input  logic [NUM_REQ-1:0]            lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          lock_err,
    output logic                          bus_en,
    output logic                          bus_we,
    output logic [ADDR_WIDTH-1:0]         bus_addr,
    output logic [DATA_WIDTH-1:0]         bus_wdata,
    input  logic [DATA_WIDTH-1:0]         bus_rdata
);

    localparam int IDW  = id_width(NUM_REQ);
    localparam int PIPE = RD_LATENCY + 1;
    localparam int CW   = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]            state;
    logic [IDW-1:0]        owner;
    logic [IDW-1:0]        ptr;
    logic [CW-1:0]         tmo_cnt;
    logic [NUM_REQ-1:0]    rr_gnt;
    logic                  xfer;
    logic [IDW-1:0]        gid;
    logic                  sel_we;
    logic                  sel_lock;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [PIPE-1:0]       pipe_vld;
    logic [IDW-1:0]        pipe_id [PIPE];

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req (req),
        .ptr (ptr),
        .gnt (rr_gnt)
    );

    // While locked only the owner can win, even if other lanes are waiting.
    always_comb begin
        gnt = '0;
        if (state == ST_LOCKED)
            gnt[owner] = req[owner];
        else
            gnt = rr_gnt;
    end

    always_comb begin
        gid       = '0;
        sel_we    = 1'b0;
        sel_lock  = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gid       = IDW'(i);
                sel_we    = we[i];
                sel_lock  = lock[i];
                sel_addr  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign xfer = |gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            owner    <= '0;
            ptr      <= '0;
            tmo_cnt  <= '0;
            lock_err <= 1'b0;
        end else begin
            lock_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (xfer) begin
                        ptr <= IDW'(wrap_inc(int'(gid), NUM_REQ));
                        if (sel_lock) begin
                            state   <= ST_LOCKED;
                            owner   <= gid;
                            tmo_cnt <= '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (xfer) begin
                        tmo_cnt <= '0;
                        if (!sel_lock) begin
                            state <= ST_IDLE;
                            ptr   <= IDW'(wrap_inc(int'(owner), NUM_REQ));
                        end
                    end else if (tmo_cnt == CW'(LOCK_TIMEOUT - 1)) begin
                        state    <= ST_IDLE;
                        ptr      <= IDW'(wrap_inc(int'(owner), NUM_REQ));
                        tmo_cnt  <= '0;
                        lock_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_en    <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            bus_en <= xfer;
            bus_we <= xfer & sel_we;
            if (xfer) begin
                bus_addr  <= sel_addr;
                bus_wdata <= sel_wdata;
            end
        end
    end

    // Owner id rides alongside the BRAM latency so data lands on the right lane.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            for (int k = 0; k < PIPE; k++)
                pipe_id[k] <= '0;
            rvalid <= '0;
            rdata  <= '0;
        end else begin
            pipe_vld   <= {pipe_vld[PIPE-2:0], xfer & ~sel_we};
            pipe_id[0] <= gid;
            for (int k = 1; k < PIPE; k++)
                pipe_id[k] <= pipe_id[k-1];
            rvalid <= '0;
            if (pipe_vld[PIPE-1]) begin
                rvalid[pipe_id[PIPE-1]] <= 1'b1;
                rdata                   <= bus_rdata;
            end
        end
    end

endmodule

// File: tb/tb_cnt_bus_arbiter.sv
// Directed self-checking bench for cnt_bus_arbiter with a 2-cycle BRAM model.
module tb_cnt_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req, we, lock;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [3:0]  gnt, rvalid;
    logic [15:0] rdata;
    logic        lock_err, bus_en, bus_we;
    logic [7:0]  bus_addr;
    logic [15:0] bus_wdata, bus_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int bad;

    logic [15:0] mem [256];
    logic [15:0] rd_q1, rd_q2;
    logic [3:0]  exp_g, exp_rv;
    logic [15:0] exp_d;

    always #5 clk = ~clk;

    cnt_bus_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .lock      (lock),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .lock_err  (lock_err),
        .bus_en    (bus_en),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata)
    );

    // BRAM model: contents are (re)loaded while reset is held low.
    assign bus_rdata = rd_q2;
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++)
                mem[i] <= 16'(i) ^ 16'h5A00;
            mem[8'h10] <= 16'hBEEF;
            for (int i = 0; i < 5; i++)
                mem[8'h20 + i] <= 16'hA000 + 16'(i);
            mem[8'h60] <= 16'h6060;
            mem[8'h63] <= 16'h6363;
        end else if (bus_en) begin
            if (bus_we)
                mem[bus_addr] <= bus_wdata;
            else
                rd_q1 <= mem[bus_addr];
        end
        rd_q2 <= rd_q1;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_lane(input int i, input logic r, input logic w, input logic l,
                            input logic [7:0] a, input logic [15:0] d);
        req[i]           = r;
        we[i]            = w;
        lock[i]          = l;
        addr[i*8 +: 8]   = a;
        wdata[i*16 +: 16] = d;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        #1;
        check_output("rst_gnt", gnt, 0);
        check_output("rst_bus_en", bus_en, 0);
        check_output("rst_bus_we", bus_we, 0);
        check_output("rst_bus_addr", bus_addr, 0);
        check_output("rst_bus_wdata", bus_wdata, 0);
        check_output("rst_rvalid", rvalid, 0);
        check_output("rst_rdata", rdata, 0);
        check_output("rst_lock_err", lock_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fairness: all four requesting from pointer 0.
        for (int i = 0; i < 4; i++)
            set_lane(i, 1'b1, 1'b0, 1'b0, 8'(64 + i), 16'h0);
        for (int k = 0; k < 8; k++) begin
            #1;
            check_output("fair_gnt", gnt, 32'(1 << (k % 4)));
            @(negedge clk);
            check_output("fair_bus_en", bus_en, 1);
            check_output("fair_bus_addr", bus_addr, 32'(64 + (k % 4)));
        end
        req = '0;
        repeat (6) @(negedge clk);

        // Single read by requester 2.
        set_lane(2, 1'b1, 1'b0, 1'b0, 8'h10, 16'h0);
        #1 check_output("rd_gnt", gnt, 4'b0100);
        @(negedge clk);
        req = '0;
        check_output("rd_bus_en", bus_en, 1);
        check_output("rd_bus_we", bus_we, 0);
        check_output("rd_bus_addr", bus_addr, 8'h10);
        @(negedge clk) check_output("rd_rvalid_early2", rvalid, 0);
        @(negedge clk) check_output("rd_rvalid_early3", rvalid, 0);
        @(negedge clk);
        check_output("rd_rvalid", rvalid, 4'b0100);
        check_output("rd_rdata", rdata, 16'hBEEF);
        @(negedge clk);
        check_output("rd_rvalid_pulse", rvalid, 0);
        check_output("rd_bus_en_off", bus_en, 0);
        repeat (2) @(negedge clk);

        // Write by 0, then read-after-write by 1.
        set_lane(0, 1'b1, 1'b1, 1'b0, 8'h30, 16'h1234);
        #1 check_output("rw_wr_gnt", gnt, 4'b0001);
        @(negedge clk);
        set_lane(0, 1'b0, 1'b0, 1'b0, 8'h30, 16'h0);
        set_lane(1, 1'b1, 1'b0, 1'b0, 8'h30, 16'h0);
        #1;
        check_output("rw_bus_we", bus_we, 1);
        check_output("rw_bus_addr", bus_addr, 8'h30);
        check_output("rw_bus_wdata", bus_wdata, 16'h1234);
        check_output("rw_rd_gnt", gnt, 4'b0010);
        @(negedge clk);
        req = '0;
        check_output("rw_rd_bus_we", bus_we, 0);
        @(negedge clk) check_output("rw_rvalid_n3", rvalid, 0);
        @(negedge clk) check_output("rw_no_wr_rvalid", rvalid, 0);
        @(negedge clk);
        check_output("rw_rvalid", rvalid, 4'b0010);
        check_output("rw_rdata", rdata, 16'h1234);
        repeat (3) @(negedge clk);

        // One write by requester 0 leaves the pointer at 1.
        set_lane(0, 1'b1, 1'b1, 1'b0, 8'h50, 16'h0);
        #1 check_output("prep_gnt", gnt, 4'b0001);
        @(negedge clk);
        req = '0; we = '0;
        repeat (5) @(negedge clk);

        // Locked burst by 1 while 0 and 3 keep requesting.
        set_lane(0, 1'b0, 1'b0, 1'b0, 8'h60, 16'h0);
        set_lane(3, 1'b0, 1'b0, 1'b0, 8'h63, 16'h0);
        for (int c = 0; c <= 10; c++) begin
            if (c < 5) begin
                req        = 4'b1011;
                lock[1]    = (c < 4);
                addr[15:8] = 8'(32 + c);
            end else if (c == 5) begin
                req = 4'b1001;
            end else if (c == 6) begin
                req = 4'b0001;
            end else begin
                req = 4'b0000;
            end
            #1;
            exp_g  = (c < 5) ? 4'b0010 : (c == 5) ? 4'b1000 : (c == 6) ? 4'b0001 : 4'b0000;
            exp_rv = 4'b0000;
            exp_d  = 16'h0;
            if (c >= 4 && c <= 8) begin
                exp_rv = 4'b0010;
                exp_d  = 16'hA000 + 16'(c - 4);
            end else if (c == 9) begin
                exp_rv = 4'b1000;
                exp_d  = 16'h6363;
            end else if (c == 10) begin
                exp_rv = 4'b0001;
                exp_d  = 16'h6060;
            end
            check_output("burst_gnt", gnt, exp_g);
            check_output("burst_rvalid", rvalid, exp_rv);
            if (exp_rv != 4'b0000)
                check_output("burst_rdata", rdata, exp_d);
            @(negedge clk);
        end
        lock = '0;

        // Lock timeout: 0 locks and goes quiet, 2 waits.
        set_lane(0, 1'b1, 1'b0, 1'b1, 8'h70, 16'h0);
        #1 check_output("tmo_lock_gnt", gnt, 4'b0001);
        @(negedge clk);
        set_lane(0, 1'b0, 1'b0, 1'b0, 8'h70, 16'h0);
        set_lane(2, 1'b1, 1'b0, 1'b0, 8'h72, 16'h0);
        bad = 0;
        for (int n = 1; n <= 64; n++) begin
            #1;
            if (gnt !== 4'b0000 || lock_err !== 1'b0)
                bad++;
            @(negedge clk);
        end
        check_output("tmo_stall_cycles_bad", bad, 0);
        #1;
        check_output("tmo_lock_err", lock_err, 1);
        check_output("tmo_gnt_after", gnt, 4'b0100);
        @(negedge clk);
        req = '0;
        check_output("tmo_lock_err_pulse", lock_err, 0);
        repeat (5) @(negedge clk);

        // Reset one cycle after a read transfer.
        set_lane(2, 1'b1, 1'b0, 1'b0, 8'h10, 16'h0);
        #1 check_output("mrst_gnt", gnt, 4'b0100);
        @(negedge clk);
        req = '0;
        check_output("mrst_bus_en_pre", bus_en, 1);
        #1 rst_n = 1'b0;
        #1;
        check_output("mrst_bus_en", bus_en, 0);
        check_output("mrst_bus_addr", bus_addr, 0);
        check_output("mrst_rvalid", rvalid, 0);
        check_output("mrst_rdata", rdata, 0);
        check_output("mrst_lock_err", lock_err, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int n = 0; n < 6; n++) begin
            #1;
            if (rvalid !== 4'b0000)
                bad++;
            @(negedge clk);
        end
        check_output("mrst_no_rvalid_cycles_bad", bad, 0);
        req = 4'b1111; we = '0;
        #1 check_output("mrst_ptr_zero_gnt", gnt, 4'b0001);
        @(negedge clk);
        req = '0;
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
